// File: rtl/sw_time_set_pkg.sv
// Shared definitions for the switch conditioning and time-set controller.
// Holds button indices, the set-mode FSM state encoding and the field encoding.
package sw_time_set_pkg;

    localparam int unsigned NUM_BTN  = 4;

    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_NEXT = 1;
    localparam int unsigned BTN_UP   = 2;
    localparam int unsigned BTN_DOWN = 3;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StEdit   = 2'd1,
        StCommit = 2'd2
    } state_e;

    localparam logic FLD_HOUR = 1'b0;
    localparam logic FLD_MIN  = 1'b1;

endpackage

// File: rtl/sw_time_set_if.sv
// Time bus between the time-set controller, the watch counter and the LCD stage.
//   cur_*   : running time from the watch counter, BCD
//   hour_*, min_* : edit registers, BCD; only valid to sample while load is high
//   load    : one-cycle commit strobe; consumer loads digits and zeroes seconds
// master = the time-set controller, slave = the consumer of the edited time.
interface sw_time_set_if;

    logic [1:0] cur_hour_10;
    logic [3:0] cur_hour_1;
    logic [2:0] cur_min_10;
    logic [3:0] cur_min_1;

    logic [1:0] hour_10;
    logic [3:0] hour_1;
    logic [2:0] min_10;
    logic [3:0] min_1;
    logic       load;

    modport master (
        input  cur_hour_10, cur_hour_1, cur_min_10, cur_min_1,
        output hour_10, hour_1, min_10, min_1, load
    );

    modport slave (
        output cur_hour_10, cur_hour_1, cur_min_10, cur_min_1,
        input  hour_10, hour_1, min_10, min_1, load
    );

endinterface

// File: rtl/sw_debounce.sv
// Single push-button channel: 2-FF synchroniser, debouncer and press detector.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   sw_raw : raw asynchronous button level, high = pressed
//   pulse  : one-cycle pulse on the debounced rising edge (release gives none)
// The debounced level only changes after DEB_CYCLES consecutive synchronised
// samples that disagree with it; any agreeing sample restarts the count.
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic pulse
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d, deb_d1_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= 1'b0;
            deb_d1_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            deb_d1_q <= deb_q;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            // This is the DEB_CYCLES-th disagreeing sample in a row.
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign pulse = deb_q & ~deb_d1_q;

endmodule

// File: rtl/sw_time_set.sv
// Switch conditioning and time-set controller.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   sw_in    : raw buttons, [0]=MODE [1]=NEXT [2]=UP [3]=DOWN, high = pressed
//   sw_pulse : one-cycle debounced press pulses, one per button
//   set_mode : high while editing
//   field    : field being edited, 0 = hour, 1 = minute
//   blink    : display enable for the edited field
//   tbus     : time bus (running time in, edit registers and load strobe out)
// MODE enters edit (copying the running time), MODE again commits with a
// one-cycle load. NEXT switches field, UP/DOWN step the field in BCD.
module sw_time_set
    import sw_time_set_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned BLINK_CYCLES = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   sw_in,
    output logic [NUM_BTN-1:0]   sw_pulse,
    output logic                 set_mode,
    output logic                 field,
    output logic                 blink,
    sw_time_set_if.master        tbus
);

    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_CYCLES - 1);

    // Input conditioning, one channel per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .sw_raw (sw_in[i]),
            .pulse  (sw_pulse[i])
        );
    end

    state_e            state_q, state_d;
    logic              field_q, field_d;
    logic              blink_q, blink_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]        h10_q, h10_d;
    logic [3:0]        h1_q, h1_d;
    logic [2:0]        m10_q, m10_d;
    logic [3:0]        m1_q, m1_d;

    logic mode_p, next_p, up_p, dn_p;

    assign mode_p = sw_pulse[BTN_MODE];
    assign next_p = sw_pulse[BTN_NEXT];
    // UP and DOWN in the same cycle cancel out.
    assign up_p   = sw_pulse[BTN_UP] & ~sw_pulse[BTN_DOWN];
    assign dn_p   = sw_pulse[BTN_DOWN] & ~sw_pulse[BTN_UP];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            field_q     <= FLD_HOUR;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            h10_q       <= '0;
            h1_q        <= '0;
            m10_q       <= '0;
            m1_q        <= '0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            h10_q       <= h10_d;
            h1_q        <= h1_d;
            m10_q       <= m10_d;
            m1_q        <= m1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        h10_d       = h10_q;
        h1_d        = h1_q;
        m10_d       = m10_q;
        m1_d        = m1_q;

        unique case (state_q)
            StRun: begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
                if (mode_p) begin
                    h10_d   = tbus.cur_hour_10;
                    h1_d    = tbus.cur_hour_1;
                    m10_d   = tbus.cur_min_10;
                    m1_d    = tbus.cur_min_1;
                    field_d = FLD_HOUR;
                    state_d = StEdit;
                end
            end

            StEdit: begin
                if (mode_p) begin
                    state_d     = StCommit;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else if (next_p) begin
                    field_d     = ~field_q;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else if (up_p || dn_p) begin
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    if (field_q == FLD_HOUR) begin
                        if (up_p) begin
                            if (h10_q == 2'd2 && h1_q == 4'd3) begin
                                h10_d = 2'd0;
                                h1_d  = 4'd0;
                            end else if (h1_q == 4'd9) begin
                                h10_d = h10_q + 2'd1;
                                h1_d  = 4'd0;
                            end else begin
                                h1_d  = h1_q + 4'd1;
                            end
                        end else begin
                            if (h10_q == 2'd0 && h1_q == 4'd0) begin
                                h10_d = 2'd2;
                                h1_d  = 4'd3;
                            end else if (h1_q == 4'd0) begin
                                h10_d = h10_q - 2'd1;
                                h1_d  = 4'd9;
                            end else begin
                                h1_d  = h1_q - 4'd1;
                            end
                        end
                    end else begin
                        if (up_p) begin
                            if (m1_q == 4'd9) begin
                                m1_d  = 4'd0;
                                m10_d = (m10_q == 3'd5) ? 3'd0 : m10_q + 3'd1;
                            end else begin
                                m1_d  = m1_q + 4'd1;
                            end
                        end else begin
                            if (m1_q == 4'd0) begin
                                m1_d  = 4'd9;
                                m10_d = (m10_q == 3'd0) ? 3'd5 : m10_q - 3'd1;
                            end else begin
                                m1_d  = m1_q - 4'd1;
                            end
                        end
                    end
                end else if (blink_cnt_q == BlinkMax) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + BlinkW'(1);
                end
            end

            StCommit: begin
                state_d     = StRun;
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end

            default: begin
                state_d     = StRun;
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end
        endcase
    end

    assign set_mode     = (state_q == StEdit);
    assign field        = field_q;
    assign blink        = blink_q;
    assign tbus.load    = (state_q == StCommit);
    assign tbus.hour_10 = h10_q;
    assign tbus.hour_1  = h1_q;
    assign tbus.min_10  = m10_q;
    assign tbus.min_1   = m1_q;

endmodule

// File: tb/tb_sw_time_set.sv
// Self-checking bench for sw_time_set with DEB_CYCLES=4, BLINK_CYCLES=8.
// A behavioural model (time held as plain hour/minute integers, buttons as
// run-length counts) is compared against the DUT on every falling edge, and
// directed scenarios add literal expectations.
module tb_sw_time_set;
    import sw_time_set_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned BLK = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] sw_in = '0;
    logic [3:0] sw_pulse;
    logic       set_mode, field, blink;

    sw_time_set_if tbus ();

    sw_time_set #(
        .DEB_CYCLES   (DEB),
        .BLINK_CYCLES (BLK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .sw_pulse (sw_pulse),
        .set_mode (set_mode),
        .field    (field),
        .blink    (blink),
        .tbus     (tbus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hm(input int h, input int m);
        return 32'({2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)});
    endfunction

    // ---------------- behavioural model ----------------
    int         m_state;          // 0 running, 1 editing, 2 committing
    int         m_hour, m_min, m_age;
    logic       m_field;
    logic [3:0] m_deb, m_pulse, m_d1, m_d2, mp;
    int         m_run [4];
    int         step;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0; m_hour = 0; m_min = 0; m_age = 0; m_field = 1'b0;
            m_deb = '0; m_pulse = '0; m_d1 = '0; m_d2 = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            mp = m_pulse;
            case (m_state)
                0: if (mp[0]) begin
                    m_hour  = int'(tbus.cur_hour_10) * 10 + int'(tbus.cur_hour_1);
                    m_min   = int'(tbus.cur_min_10) * 10 + int'(tbus.cur_min_1);
                    m_field = 1'b0;
                    m_age   = 0;
                    m_state = 1;
                end
                1: if (mp[0]) begin
                    m_state = 2;
                end else if (mp[1]) begin
                    m_field = !m_field;
                    m_age   = 0;
                end else if (mp[2] != mp[3]) begin
                    step = mp[2] ? 1 : -1;
                    if (!m_field) m_hour = (m_hour + 24 + step) % 24;
                    else          m_min  = (m_min + 60 + step) % 60;
                    m_age = 0;
                end else begin
                    m_age++;
                end
                default: m_state = 0;
            endcase
            // Raw input reaches the debouncer two edges late; a level change
            // needs DEB consecutive disagreeing samples.
            for (int i = 0; i < 4; i++) begin
                m_pulse[i] = 1'b0;
                if (m_d2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(DEB)) begin
                        m_deb[i]   = !m_deb[i];
                        m_run[i]   = 0;
                        m_pulse[i] = m_deb[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = sw_in;
        end
    end

    logic exp_blink;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_blink = (m_state != 1) || (((m_age / int'(BLK)) % 2) == 0);
            chk("sw_pulse", 32'(sw_pulse), 32'(m_pulse));
            chk("set_mode", 32'(set_mode), 32'(m_state == 1));
            chk("field", 32'(field), 32'(m_field));
            chk("blink", 32'(blink), 32'(exp_blink));
            chk("load", 32'(tbus.load), 32'(m_state == 2));
            chk("time", 32'({tbus.hour_10, tbus.hour_1, tbus.min_10, tbus.min_1}),
                hm(m_hour, m_min));
        end
    end

    // Load monitor for literal checks.
    int          n_loads = 0;
    logic [31:0] load_time;
    logic        load_setmode;
    always @(negedge clk) begin
        if (tbus.load) begin
            n_loads++;
            load_time    = 32'({tbus.hour_10, tbus.hour_1, tbus.min_10, tbus.min_1});
            load_setmode = set_mode;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        sw_in = mask;
        cyc(int'(DEB) + 4);
        sw_in = '0;
        cyc(int'(DEB) + 4);
    endtask

    function automatic logic [31:0] dut_time();
        return 32'({tbus.hour_10, tbus.hour_1, tbus.min_10, tbus.min_1});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int first, pulses, zr, k, loads0;

    initial begin
        tbus.cur_hour_10 = '0;
        tbus.cur_hour_1  = '0;
        tbus.cur_min_10  = '0;
        tbus.cur_min_1   = '0;
        #1 rst = 1'b0;
        chk_en = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("rst_blink", 32'(blink), 32'd1);
        chk("rst_setmode", 32'(set_mode), 32'd0);
        chk("rst_outputs", 32'({sw_pulse, field, tbus.load}), 32'd0);
        chk("rst_time", dut_time(), 32'd0);

        // Bounce on UP: 1,0,1 then hold.
        cyc(1);
        sw_in[2] = 1'b1; cyc(1);
        sw_in[2] = 1'b0; cyc(1);
        sw_in[2] = 1'b1;
        first = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sw_pulse[2]) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("bounce_latency", 32'(first), 32'd7);
        chk("bounce_pulses", 32'(pulses), 32'd1);
        sw_in[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sw_pulse != 4'b0) pulses++;
        end
        chk("release_pulses", 32'(pulses), 32'd0);
        chk("run_after_up", 32'(set_mode), 32'd0);

        // Enter edit from 23:59 and adjust hours.
        tbus.cur_hour_10 = 2'd2; tbus.cur_hour_1 = 4'd3;
        tbus.cur_min_10  = 3'd5; tbus.cur_min_1  = 4'd9;
        press(4'b0001);
        @(negedge clk);
        chk("enter_setmode", 32'(set_mode), 32'd1);
        chk("enter_field", 32'(field), 32'd0);
        chk("enter_time", dut_time(), 32'h11D9);
        press(4'b0100);
        @(negedge clk);
        chk("hour_up_wrap", dut_time(), hm(0, 59));
        press(4'b1000);
        press(4'b1000);
        @(negedge clk);
        chk("hour_down_wrap", dut_time(), hm(22, 59));

        // Minutes.
        press(4'b0010);
        @(negedge clk);
        chk("next_field", 32'(field), 32'd1);
        press(4'b0100);
        @(negedge clk);
        chk("min_up_wrap", dut_time(), hm(22, 0));
        press(4'b1000);
        @(negedge clk);
        chk("min_down_wrap", dut_time(), hm(22, 59));

        // Commit.
        loads0 = n_loads;
        press(4'b0001);
        chk("commit_loads", 32'(n_loads - loads0), 32'd1);
        chk("commit_time", load_time, hm(22, 59));
        chk("commit_setmode", 32'(load_setmode), 32'd0);
        chk("after_commit", 32'(set_mode), 32'd0);

        // UP+DOWN together, then MODE+UP together.
        tbus.cur_hour_10 = 2'd1; tbus.cur_hour_1 = 4'd2;
        tbus.cur_min_10  = 3'd3; tbus.cur_min_1  = 4'd4;
        press(4'b0001);
        press(4'b1100);
        @(negedge clk);
        chk("updown_ignored", dut_time(), hm(12, 34));
        loads0 = n_loads;
        press(4'b0101);
        chk("mode_up_loads", 32'(n_loads - loads0), 32'd1);
        chk("mode_up_time", load_time, hm(12, 34));

        // Blink in edit.
        press(4'b0001);
        k = 0;
        while (!blink && k < 40) begin @(negedge clk); k++; end
        while (blink && k < 40) begin @(negedge clk); k++; end
        zr = 0;
        while (!blink && k < 80) begin zr++; @(negedge clk); k++; end
        chk("blink_low_run", 32'(zr), 32'd8);
        repeat (2) @(negedge clk);
        sw_in = 4'b0010;
        k = 0;
        while (!sw_pulse[1] && k < 20) begin @(negedge clk); k++; end
        chk("next_pulse_seen", 32'(sw_pulse[1]), 32'd1);
        chk("blink_before_next", 32'(blink), 32'd0);
        @(negedge clk);
        chk("blink_forced", 32'(blink), 32'd1);
        chk("next_field_min", 32'(field), 32'd1);
        sw_in = '0;
        cyc(int'(DEB) + 4);

        // Reset mid-edit.
        chk("pre_reset_edit", 32'(set_mode), 32'd1);
        loads0 = n_loads;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_setmode", 32'(set_mode), 32'd0);
        chk("abort_blink", 32'(blink), 32'd1);
        chk("abort_time", dut_time(), 32'd0);
        chk("abort_field_load", 32'({field, tbus.load}), 32'd0);
        cyc(3);
        rst = 1'b1;
        cyc(int'(DEB) + 4);
        chk("abort_no_load", 32'(n_loads - loads0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sw_time_set.md
# sw_time_set

Switch conditioning and time-set controller, directly upstream of the watch counter and the LCD list stage. It synchronises and debounces the four raw push-buttons, turns them into single-cycle press pulses, and runs a set-mode state machine that edits hours and minutes in BCD. On commit it emits a one-cycle load with the new time. Outside set mode, the running time passes through untouched.

## Interface
- DEB_CYCLES, default 500000: consecutive stable cycles before a debounced level changes (10 ms at 50 MHz).
- BLINK_CYCLES, default 12500000: half-period of the edit-field blink.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- sw_in  in  4  raw buttons, high = pressed. [0]=MODE, [1]=NEXT, [2]=UP, [3]=DOWN.
- cur_hour_10 in 2, cur_hour_1 in 4, cur_min_10 in 3, cur_min_1 in 4: running time, in BCD.
- sw_pulse  out  4  one-cycle press pulses, one bit per button.
- set_mode  out  1  high while editing.
- field  out  1  field being edited: 0 = hour, 1 = minute.
- blink  out  1  display-enable for the edited field.
- hour_10 2, hour_1 4, min_10 3, min_1 4  out: edit registers, in BCD.
- load  out  1  one-cycle commit strobe. The consumer loads these digits and zeroes seconds.

## Operation
- Input path: each sw_in bit passes through a 2-FF synchroniser, then a per-channel debouncer.
- Debouncer behaviour:
  - The counter clears whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
- sw_pulse[i] = debounced rising edge (debounced AND NOT debounced_d1). Release edges produce no pulse.
- FSM states: RUN, EDIT, COMMIT.
  - RUN: on MODE pulse, copy the cur_* digits into the edit registers, set field=0, go to EDIT.
  - EDIT: on MODE pulse, go to COMMIT. On NEXT pulse, toggle field. UP/DOWN modify the selected field.
  - COMMIT: load=1 for exactly one cycle, then go to RUN unconditionally.
- Arithmetic: BCD only, and the digits never hold an illegal value.
  - Hour UP: 09→10, 19→20, 23→00.
  - Hour DOWN: 10→09, 00→23.
  - Minute UP: x9→(x+1)0, 59→00.
  - Minute DOWN: x0→(x-1)9, 00→59.
- Simultaneous pulses in one cycle:
  - MODE has priority and all other pulses are discarded.
  - NEXT beats UP/DOWN.
  - UP and DOWN together are ignored.
- Outside EDIT, UP/DOWN/NEXT pulses still appear on sw_pulse but do not change the FSM.
- Blink behaviour:
  - In RUN and COMMIT, blink=1 and the blink counter is held at 0.
  - In EDIT, blink toggles every BLINK_CYCLES cycles.
  - Any NEXT, UP or DOWN action, and entry to EDIT, forces blink=1 and clears the counter.
- Edit registers hold their last value in RUN. Consumers must only sample them on load.

## Timing
- Reset values: all outputs 0 except blink=1. FSM=RUN, debounced levels=0, counters=0.
- Press latency, for a raw rising edge held stable:
  - Debounced level rises at cycle 2+DEB_CYCLES.
  - sw_pulse is high in the following cycle only.
- Glitches shorter than DEB_CYCLES cycles produce no pulse.
- The FSM reacts in the cycle sw_pulse is high. State, field and digit updates are visible on the next edge.
- load asserts the cycle after the MODE pulse that exits EDIT.
- A new MODE press needs a full debounce period, so back-to-back commits are impossible.
- Asynchronous reset mid-edit aborts with no load pulse. Edit registers clear to 00:00.

## Structure
- Shared package holds:
  - button index constants BTN_MODE=0, BTN_NEXT=1, BTN_UP=2, BTN_DOWN=3;
  - FSM state encoding (RUN/EDIT/COMMIT);
  - field encoding FLD_HOUR=0, FLD_MIN=1.
- One sub-module, sw_debounce: a single channel with the synchroniser, counter and edge detector, parameterised by DEB_CYCLES. It is instantiated four times.
- BCD increment/decrement stays inline.

## Test plan
All scenarios use DEB_CYCLES=4 and BLINK_CYCLES=8.
- Reset, then hold sw_in=0: blink=1, all other outputs 0, state RUN.
- Bounce sw_in[2] 1,0,1 at 1-cycle spacing, then hold high: exactly one sw_pulse[2], 7 cycles after the final rise. Release: no pulse.
- cur=23:59, MODE press → set_mode=1, field=0, digits 23:59. UP → 00:59. DOWN twice → 22:59.
- NEXT, then with minute=59 press UP → 00. DOWN → 59. Then MODE → load high one cycle with 22:59, set_mode=0.
- Assert UP and DOWN pulses in the same cycle in EDIT → digits unchanged. MODE with UP in the same cycle → COMMIT, digits unchanged.
- In EDIT: blink toggles every 8 cycles, and a NEXT press forces blink=1. Drop rst mid-edit → no load, outputs at reset values.
